// File: rtl/dm_rmw_port.sv
// dm_rmw_port: load/store unit for a word-wide DM; sub-word stores become read-modify-write.
module dm_rmw_port #(
    parameter int DM_WORDS = 3072
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] dm_a,
    output logic [31:0] dm_wd,
    output logic [31:0] dm_pc,
    output logic        dm_wr,
    input  logic [31:0] dm_rd
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
    state_t      state, state_nx;
    logic        we_q, sgn_q, err;
    logic [1:0]  size_q, off_q;
    logic [31:0] wdata_q, ext, mask, merged;
    logic [15:0] lane;
    logic [4:0]  sh;

    assign err = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] != 2'b00) || req_addr[31:2] >= 30'(DM_WORDS);
    // Lane offset in bits; half accesses are aligned so the byte offset works for both sizes.
    assign sh = {off_q, 3'b000};
    assign lane = 16'(dm_rd >> sh);
    assign ext = size_q == 2'b00 ? {{24{sgn_q & lane[7]}}, lane[7:0]} :
                 size_q == 2'b01 ? {{16{sgn_q & lane[15]}}, lane} : dm_rd;
    assign mask = (size_q == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << sh;
    assign merged = (dm_rd & ~mask) | ((wdata_q << sh) & mask);

    always_ff @(posedge Clk or negedge Reset)
        if (!Reset) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (req_valid) state_nx = err ? RESP : (req_we && req_size == 2'b10) ? WRITE : READ;
            READ: state_nx = we_q ? WRITE : RESP;
            WRITE: state_nx = RESP;
            RESP: if (rsp_ready) state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready = state == IDLE;
        rsp_valid = state == RESP;
        dm_wr = state == WRITE;
    end

    always_ff @(posedge Clk or negedge Reset)
        if (!Reset) begin
            we_q <= 1'b0;
            sgn_q <= 1'b0;
            size_q <= 2'b00;
            off_q <= 2'b00;
            wdata_q <= '0;
            dm_a <= '0;
            dm_wd <= '0;
            dm_pc <= '0;
            rsp_rdata <= '0;
            rsp_err <= 1'b0;
        end else if (state == IDLE && req_valid) begin
            we_q <= req_we;
            sgn_q <= req_signed;
            size_q <= req_size;
            off_q <= req_addr[1:0];
            wdata_q <= req_wdata;
            dm_a <= {req_addr[31:2], 2'b00};
            dm_wd <= req_wdata;
            dm_pc <= req_pc;
            rsp_rdata <= '0;
            rsp_err <= err;
        end else if (state == READ) begin
            if (we_q) dm_wd <= merged;
            else rsp_rdata <= ext;
        end
endmodule

// File: tb/tb_dm_rmw_port.sv
// tb_dm_rmw_port: directed and random requests checked against a byte-addressed memory model.
module tb_dm_rmw_port;
    localparam int DM_WORDS = 3072;
    localparam int DM_BYTES = 4 * DM_WORDS;

    logic        clk = 0, reset = 0;
    logic        req_valid = 0, req_we = 0, req_signed = 0, rsp_ready = 0;
    logic [1:0]  req_size = 0;
    logic [31:0] req_addr = 0, req_wdata = 0, req_pc = 0;
    logic        req_ready, rsp_valid, rsp_err, dm_wr;
    logic [31:0] rsp_rdata, dm_a, dm_wd, dm_pc, dm_rd;

    logic [31:0] mem [0:DM_WORDS-1];
    logic [7:0]  rm [0:DM_BYTES-1];
    int          checks = 0, errors = 0, wr_cnt = 0;
    logic [31:0] last_a, last_wd, last_pc;

    dm_rmw_port #(.DM_WORDS(DM_WORDS)) dut (
        .Clk(clk), .Reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .dm_a(dm_a), .dm_wd(dm_wd), .dm_pc(dm_pc), .dm_wr(dm_wr), .dm_rd(dm_rd)
    );

    always #5 clk = ~clk;

    assign dm_rd = dm_a[31:2] < 30'(DM_WORDS) ? mem[dm_a[31:2]] : 32'h0;

    always @(posedge clk)
        if (dm_wr) begin
            if (dm_a[31:2] < 30'(DM_WORDS)) mem[dm_a[31:2]] <= dm_wd;
            wr_cnt <= wr_cnt + 1;
            last_a <= dm_a;
            last_wd <= dm_wd;
            last_pc <= dm_pc;
        end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic mdl_err(input logic [1:0] sz, input logic [31:0] a);
        return sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) || a >= 32'(DM_BYTES);
    endfunction

    function automatic logic [31:0] mdl_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
        int n;
        logic [31:0] v;
        n = 1 << sz;
        v = 0;
        for (int i = 0; i < n; i++) v = v | (32'(rm[a + 32'(i)]) << (8 * i));
        if (sg && n < 4 && v[8 * n - 1]) v = v | (32'hffff_ffff << (8 * n));
        return v;
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [31:0] b;
        b = a & ~32'd3;
        return {rm[b + 3], rm[b + 2], rm[b + 1], rm[b]};
    endfunction

    task automatic xact(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] pc, input string tag);
        logic e;
        logic [31:0] er;
        int el, ew, w0, lat;
        e = mdl_err(sz, a);
        er = (e || we) ? 32'h0 : mdl_load(sz, sg, a);
        el = e ? 1 : (we && sz == 2'd2) ? 2 : we ? 3 : 2;
        ew = (we && !e) ? 1 : 0;
        if (ew == 1) for (int i = 0; i < (1 << sz); i++) rm[a + 32'(i)] = wd[8 * i +: 8];
        @(negedge clk);
        chk({tag, " ready"}, 32'(req_ready), 32'd1);
        req_valid = 1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd; req_pc = pc;
        w0 = wr_cnt;
        @(posedge clk); #1;
        req_valid = 0;
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(el));
        chk({tag, " err"}, 32'(rsp_err), 32'(e));
        chk({tag, " rdata"}, rsp_rdata, er);
        chk({tag, " writes"}, 32'(wr_cnt - w0), 32'(ew));
        if (ew == 1) begin
            chk({tag, " dm_a"}, last_a, a & ~32'd3);
            chk({tag, " dm_wd"}, last_wd, word_of(a));
            chk({tag, " dm_pc"}, last_pc, pc);
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        chk({tag, " released"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " dm_wr"}, 32'(dm_wr), 32'd0);
        chk({tag, " rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, " rsp_rdata"}, rsp_rdata, 32'h0);
        chk({tag, " dm_a"}, dm_a, 32'h0);
        chk({tag, " dm_wd"}, dm_wd, 32'h0);
        chk({tag, " dm_pc"}, dm_pc, 32'h0);
    endtask

    initial begin
        logic [31:0] w, held, a, w0;
        logic [1:0]  sz;
        for (int i = 0; i < DM_WORDS; i++) begin
            w = $urandom;
            mem[i] = w;
            for (int j = 0; j < 4; j++) rm[4 * i + j] = w[8 * j +: 8];
        end
        #3;
        chk_reset_outputs("reset");
        @(negedge clk);
        reset = 1;

        xact(1, 2'd2, 0, 32'h10, 32'hdead_beef, 32'h100, "sw");
        xact(0, 2'd2, 0, 32'h10, 32'h0, 32'h104, "lw");
        chk("lw direct", rsp_rdata, 32'hdead_beef);
        xact(1, 2'd2, 0, 32'h10, 32'h1122_3344, 32'h108, "sw2");
        xact(1, 2'd0, 0, 32'h11, 32'h5555_55aa, 32'h10c, "sb");
        chk("sb merged", last_wd, 32'h1122_aa44);
        xact(0, 2'd0, 1, 32'h11, 32'h0, 32'h110, "lbs");
        chk("lbs direct", rsp_rdata, 32'hffff_ffaa);
        xact(0, 2'd0, 0, 32'h11, 32'h0, 32'h114, "lbu");
        xact(1, 2'd2, 0, 32'h10, 32'h1122_3344, 32'h118, "sw3");
        xact(1, 2'd1, 0, 32'h12, 32'h0000_8001, 32'h11c, "sh");
        chk("sh merged", last_wd, 32'h8001_3344);
        xact(0, 2'd1, 1, 32'h12, 32'h0, 32'h120, "lhs");
        xact(0, 2'd1, 0, 32'h12, 32'h0, 32'h124, "lhu");
        chk("lhu direct", rsp_rdata, 32'h0000_8001);

        xact(0, 2'd2, 0, 32'h13, 32'h0, 32'h200, "err lw mis");
        xact(1, 2'd1, 0, 32'h11, 32'h1234, 32'h204, "err sh mis");
        xact(0, 2'd3, 0, 32'h20, 32'h0, 32'h208, "err size");
        xact(1, 2'd3, 0, 32'h20, 32'h1, 32'h20c, "err size st");
        xact(0, 2'd2, 0, 32'h3000, 32'h0, 32'h210, "err range");
        xact(1, 2'd0, 0, 32'h3003, 32'h7, 32'h214, "err range sb");
        xact(0, 2'd2, 0, 32'h2ffc, 32'h0, 32'h218, "last word");

        // Backpressure: a second request waits behind a stalled response.
        @(negedge clk);
        req_valid = 1; req_we = 0; req_size = 2'd2; req_signed = 0; req_addr = 32'h10; req_pc = 32'h300;
        @(posedge clk); #1;
        req_addr = 32'h14;
        @(posedge clk); #1;
        chk("bp valid", 32'(rsp_valid), 32'd1);
        chk("bp rdata", rsp_rdata, mdl_load(2'd2, 0, 32'h10));
        held = rsp_rdata;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp hold valid", 32'(rsp_valid), 32'd1);
            chk("bp hold rdata", rsp_rdata, held);
            chk("bp hold err", 32'(rsp_err), 32'd0);
            chk("bp hold ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        chk("bp idle ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 0;
        chk("bp second busy", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("bp second valid", 32'(rsp_valid), 32'd1);
        chk("bp second rdata", rsp_rdata, mdl_load(2'd2, 0, 32'h14));
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;

        // Reset during the WRITE cycle of a half store must leave memory untouched.
        xact(1, 2'd2, 0, 32'h10, 32'h1122_3344, 32'h400, "pre rst sw");
        w0 = wr_cnt;
        @(negedge clk);
        req_valid = 1; req_we = 1; req_size = 2'd1; req_addr = 32'h12; req_wdata = 32'h8001; req_pc = 32'h404;
        @(posedge clk); #1;
        req_valid = 0;
        @(posedge clk);
        @(negedge clk);
        chk("rst in write", 32'(dm_wr), 32'd1);
        reset = 0;
        #1;
        chk_reset_outputs("mid reset");
        @(negedge clk);
        reset = 1;
        @(posedge clk); #1;
        chk("rst no write", 32'(wr_cnt - w0), 32'd0);
        chk("rst mem", mem[4], 32'h1122_3344);
        chk_reset_outputs("post reset");
        xact(0, 2'd2, 0, 32'h10, 32'h0, 32'h408, "post rst lw");

        for (int i = 0; i < 300; i++) begin
            sz = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 7) == 0) ? 32'(DM_BYTES - 8 + $urandom_range(0, 15)) : 32'($urandom_range(0, 63));
            xact(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
